// File: rtl/polar_encoder_seq_if.sv
// Valid/ready bus for polar_encoder_seq: information word in, codeword out.
interface polar_encoder_seq_if #(
  parameter int N = 16,
  parameter int K = 8
);
  logic [K-1:0] info_in;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] cw_out;
  logic         out_valid;
  logic         out_ready;

  // Source/sink side: supplies info words and accepts codewords
  modport master (
    output info_in, in_valid, out_ready,
    input  in_ready, cw_out, out_valid
  );

  // Encoder side
  modport slave (
    input  info_in, in_valid, out_ready,
    output in_ready, cw_out, out_valid
  );
endinterface

// File: rtl/polar_encoder_seq.sv
// Iterative polar encoder: scatters K info bits onto the INFO_MASK positions
// of an N-bit u vector and applies x = u * F^(kron n), one butterfly stage
// per clock, with no bit-reversal permutation.
// Optional macro POLAR_ENC_SYS_EN: systematic encoding (first pass, mask
// frozen positions, second pass).
module polar_encoder_seq #(
  parameter int              N         = 16,
  parameter int              K         = 8,
  parameter logic [N-1:0]    INFO_MASK = 16'hFCC0
) (
  input  logic              clk,
  input  logic              rst,
  polar_encoder_seq_if.slave bus,
  output logic              busy
);

  localparam int             LOGN = $clog2(N);
  localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);

`ifdef POLAR_ENC_SYS_EN
  typedef enum logic [1:0] {IDLE, ENC, MASK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
`endif

  state_t          state;
  logic [N-1:0]    u;
  logic [LOGN-1:0] stage;
  logic [N-1:0]    cw_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
`ifdef POLAR_ENC_SYS_EN
  logic            second_pass;
`endif

  // Place info bits on the set positions of INFO_MASK, lowest index first.
  function automatic logic [N-1:0] scatter(input logic [K-1:0] info);
    logic [N-1:0] v;
    logic [K-1:0] rem;
    v   = '0;
    rem = info;
    for (int unsigned i = 0; i < N; i++) begin
      if (INFO_MASK[i]) begin
        v[i] = rem[0];
        rem  = rem >> 1;
      end
    end
    return v;
  endfunction

  // One butterfly stage s: u[j] ^= u[j + 2^s] for every j with bit s clear.
  // The stage index is decoded against constants so each stage unrolls to
  // fixed wiring rather than a variable shifter.
  function automatic logic [N-1:0] butterfly(input logic [N-1:0] v,
                                             input logic [LOGN-1:0] s);
    logic [N-1:0] r;
    r = v;
    for (int unsigned st = 0; st < LOGN; st++) begin
      if (s == LOGN'(st)) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (((j >> st) & 1) == 0)
            r[j] = v[j] ^ v[j + (1 << st)];
        end
      end
    end
    return r;
  endfunction

  // Control FSM and datapath; all handshake outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      u           <= '0;
      stage       <= '0;
      cw_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef POLAR_ENC_SYS_EN
      second_pass <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            u          <= scatter(bus.info_in);
            stage      <= '0;
            state      <= ENC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ENC: begin
          u <= butterfly(u, stage);
          if (stage == LAST_STAGE) begin
            stage <= '0;
`ifdef POLAR_ENC_SYS_EN
            if (!second_pass) begin
              state <= MASK;
            end else begin
              state       <= DONE;
              cw_q        <= butterfly(u, stage);
              out_valid_q <= 1'b1;
            end
`else
            state       <= DONE;
            cw_q        <= butterfly(u, stage);
            out_valid_q <= 1'b1;
`endif
          end else begin
            stage <= stage + 1'b1;
          end
        end
`ifdef POLAR_ENC_SYS_EN
        MASK: begin
          u           <= u & INFO_MASK;
          second_pass <= 1'b1;
          state       <= ENC;
        end
`endif
        DONE: begin
          if (out_valid_q && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef POLAR_ENC_SYS_EN
            second_pass <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cw_out    = cw_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_polar_encoder_seq.sv
// Self-checking bench for polar_encoder_seq (N=16, K=8, mask FCC0).
// Reference: closed-form x[j] = XOR of u[k] over all k whose bits cover j.
module tb_polar_encoder_seq;
  localparam int           N    = 16;
  localparam int           K    = 8;
  localparam logic [N-1:0] MASK = 16'hFCC0;
`ifdef POLAR_ENC_SYS_EN
  localparam int           LAT  = 9;
`else
  localparam int           LAT  = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  polar_encoder_seq_if #(.N(N), .K(K)) bus ();

  polar_encoder_seq #(.N(N), .K(K), .INFO_MASK(MASK)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [N-1:0] got,
                          input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] scatter_ref(input logic [K-1:0] info);
    logic [N-1:0] v;
    int           k;
    v = '0;
    k = 0;
    for (int p = 0; p < N; p++) begin
      if (MASK[p]) begin
        v[p] = info[k];
        k++;
      end
    end
    return v;
  endfunction

  function automatic logic [N-1:0] transform_ref(input logic [N-1:0] v);
    logic [N-1:0] x;
    for (int j = 0; j < N; j++) begin
      x[j] = 1'b0;
      for (int k = 0; k < N; k++)
        if ((k & j) == j) x[j] = x[j] ^ v[k];
    end
    return x;
  endfunction

  function automatic logic [N-1:0] encode_ref(input logic [K-1:0] info);
    logic [N-1:0] x;
    x = transform_ref(scatter_ref(info));
`ifdef POLAR_ENC_SYS_EN
    x = transform_ref(x & MASK);
`endif
    return x;
  endfunction

  task automatic run_word(input logic [K-1:0] info, input int hold);
    int           t;
    logic [N-1:0] exp;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check_eq("in_ready_idle", N'(bus.in_ready), N'(1));
    bus.info_in  = info;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.info_in  = K'($urandom);
    check_eq("in_ready_enc", N'(bus.in_ready), N'(0));
    check_eq("busy_enc", N'(busy), N'(1));
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check_eq("latency", N'(t), N'(LAT));
    exp = encode_ref(info);
    check_eq("cw", bus.cw_out, exp);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid  = 1'b1;
      bus.info_in   = K'($urandom);
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      check_eq("cw_hold", bus.cw_out, exp);
      check_eq("in_ready_done", N'(bus.in_ready), N'(0));
      check_eq("out_valid_hold", N'(bus.out_valid), N'(1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq("out_valid_clr", N'(bus.out_valid), N'(0));
    check_eq("in_ready_back", N'(bus.in_ready), N'(1));
    check_eq("busy_clr", N'(busy), N'(0));
  endtask

  task automatic directed(input logic [K-1:0] info, input logic [N-1:0] cw_ns,
                          input int hold);
    run_word(info, hold);
`ifndef POLAR_ENC_SYS_EN
    check_eq("cw_const", bus.cw_out, cw_ns);
`endif
  endtask

  initial begin
    bus.info_in   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", N'(bus.in_ready), N'(1));
    check_eq("rst_out_valid", N'(bus.out_valid), N'(0));
    check_eq("rst_busy", N'(busy), N'(0));
    check_eq("rst_cw", bus.cw_out, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    directed(8'h00, 16'h0000, 0);
    directed(8'h80, 16'hFFFF, 1);
    directed(8'h01, 16'h0055, 0);
    directed(8'h04, 16'h0505, 10);
    directed(8'hFF, encode_ref(8'hFF), 2);

`ifdef POLAR_ENC_SYS_EN
    run_word(8'h01, 0);
    check_eq("sys_info_pos", bus.cw_out & MASK, 16'h0040);
`endif

    // Reset two cycles into ENC: partial word discarded.
    bus.info_in  = 8'hA5;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", N'(bus.out_valid), N'(0));
    check_eq("midrst_busy", N'(busy), N'(0));
    check_eq("midrst_in_ready", N'(bus.in_ready), N'(1));
    check_eq("midrst_cw", bus.cw_out, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    directed(8'h80, 16'hFFFF, 0);

    for (int i = 0; i < 24; i++)
      run_word(K'($urandom), int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/polar_encoder_seq.md
Name: polar_encoder_seq

Overview:
- Iterative polar encoder; the transmit-side counterpart of the SC decoder datapath.
- Accepts K information bits and places them on the non-frozen positions of an N-bit u vector (frozen positions = 0).
- Computes x = u·F^(⊗n), F=[[1,0],[1,1]], one butterfly stage per clock; no bit-reversal permutation.
- Presents the codeword on a valid/ready output, feeding the channel model/LLR generator ahead of the decoder bench.

Parameters:
- N, 16, codeword length; power of two, 4..1024; LOGN = $clog2(N) derived internally.
- K, 8, information bits per codeword; 1..N.
- INFO_MASK, 16'hFCC0, N-bit mask; bit i=1 marks u[i] as information; popcount must equal K (N=16/K=8 reliability set {6,7,10..15}).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- info_in  in  K  information bits; info_in[0] maps to the lowest-index set bit of INFO_MASK, ascending
- in_valid  in  1  info_in valid
- in_ready  out  1  encoder can accept a new word
- cw_out  out  N  codeword; cw_out[i] = x[i]
- out_valid  out  1  cw_out valid
- out_ready  in  1  sink accepts cw_out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; u register, stage counter and cw_out = 0.
  - in_ready=1, out_valid=0, busy=0.
- FSM IDLE -> ENC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: u <= scatter(info_in, INFO_MASK), frozen bits forced 0; stage <= 0; go to ENC.
- ENC:
  - in_ready=0.
  - Each edge applies stage s=stage: for every j with bit s of j clear, u[j] <= u[j] ^ u[j + 2^s]; u[j+2^s] unchanged; stage <= stage+1.
  - After the stage with s=LOGN-1, go to DONE.
  - Exactly LOGN cycles; ENC cannot stall.
- DONE:
  - out_valid=1; cw_out = u, held stable while out_ready=0.
  - On out_valid&&out_ready at an edge: go to IDLE and clear out_valid at that edge.
- Latency: acceptance edge E0; stage edges E1..E_LOGN; out_valid high in the cycle after E_LOGN.
- Throughput: one codeword per LOGN+2 cycles when out_ready is held high.
- Handshake rules:
  - in_ready is 0 in ENC and DONE; info_in and in_valid are ignored there.
  - in_ready is a function of state only; there is no combinational path from in_valid or out_ready to in_ready or out_valid.
  - Once asserted, out_valid stays high until the handshake completes.
- Boundaries:
  - K=N: all-info, INFO_MASK all ones.
  - N=4: LOGN=2 stages.
  - The stage counter never exceeds LOGN-1 in ENC.
  - rst mid-ENC or mid-DONE: return to reset values immediately, partial word discarded, no out_valid pulse.

Optional Feature:
- Macro POLAR_ENC_SYS_EN.
- When defined (systematic encoding):
  - After the first LOGN stages, the FSM enters an extra MASK cycle: u <= u & INFO_MASK.
  - It then runs a second LOGN-stage ENC pass before DONE.
  - Info positions of cw_out then equal the scattered info_in.
  - Latency is 2·LOGN+1 edges after acceptance.
- When undefined: non-systematic encoding as above; no MASK state is synthesized.

Test Plan:
- Reset, in_valid=1, info_in=8'h00 -> accepted; out_valid rises exactly 4 cycles after the acceptance edge; cw_out=16'h0000.
- info_in=8'h80 (u15=1) -> cw_out=16'hFFFF.
- info_in=8'h01 (u6=1) -> cw_out=16'h0055; info_in=8'h04 (u10=1) -> cw_out=16'h0505.
- out_ready=0 for 10 cycles after out_valid, new in_valid offered during DONE -> cw_out held, in_ready=0, second word accepted only after the handshake.
- Assert rst two cycles into ENC -> out_valid=0, busy=0, in_ready=1 asynchronously; next word 8'h80 still yields 16'hFFFF.
- POLAR_ENC_SYS_EN defined, info_in=8'h01 -> cw_out=16'h0055 with cw_out&16'hFCC0=16'h0040; out_valid 9 cycles after acceptance.
